// File: rtl/q31_fiveway_arbiter_if.sv
// Request/grant and Q31 data bundle between five requesters and the shared selector.
interface q31_fiveway_arbiter_if;
  logic [4:0]         req;
  logic               done;
  logic signed [31:0] in0;
  logic signed [31:0] in1;
  logic signed [31:0] in2;
  logic signed [31:0] in3;
  logic signed [31:0] in4;
  logic [4:0]         grant;
  logic [2:0]         sel;
  logic signed [31:0] out;
  logic               out_valid;
  logic               timeout;

  modport master (
    output req, done, in0, in1, in2, in3, in4,
    input  grant, sel, out, out_valid, timeout
  );

  modport slave (
    input  req, done, in0, in1, in2, in3, in4,
    output grant, sel, out, out_valid, timeout
  );
endinterface

// File: rtl/q31_fiveway_arbiter.sv
// Round-robin arbiter granting one of five requesters a shared Q31 path; the owner's
// word is registered one cycle behind its select and released on done, abandon or timeout.
module q31_fiveway_arbiter #(
  parameter int MAX_HOLD = 64,
  parameter int CNT_W    = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  q31_fiveway_arbiter_if.slave   bus
);
  localparam int DATA_W = 32;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                    state_p0, state_nxt;
  logic [2:0]                last_p0, last_nxt;
  logic [2:0]                sel_p0, sel_nxt;
  logic [4:0]                grant_p0, grant_nxt;
  logic [CNT_W-1:0]          cnt_p0, cnt_nxt;
  logic                      to_p0, to_nxt;
  logic signed [DATA_W-1:0]  out_p1, out_nxt;
  logic                      vld_p1, vld_nxt;

  // Scan last+1, last+2, ... modulo 5; the nearest set request wins.
  function automatic logic [2:0] pick(input logic [4:0] r, input logic [2:0] l);
    logic [2:0] w;
    int         t;
    w = l;
    for (int k = 5; k >= 1; k--) begin
      t = int'(l) + k;
      if (t >= 5) t = t - 5;
      if (r[t]) w = 3'(t);
    end
    return w;
  endfunction

  function automatic logic signed [DATA_W-1:0] mux5(
    input logic [2:0]                s,
    input logic signed [DATA_W-1:0]  a0, a1, a2, a3, a4
  );
    case (s)
      3'd0:    return a0;
      3'd1:    return a1;
      3'd2:    return a2;
      3'd3:    return a3;
      3'd4:    return a4;
      default: return a0;
    endcase
  endfunction

  always_comb begin
    state_nxt = state_p0;
    last_nxt  = last_p0;
    sel_nxt   = sel_p0;
    grant_nxt = grant_p0;
    cnt_nxt   = cnt_p0;
    to_nxt    = 1'b0;
    out_nxt   = out_p1;
    vld_nxt   = 1'b0;
    case (state_p0)
      IDLE: begin
        grant_nxt = '0;
        if (bus.req != 5'b0) begin
          sel_nxt   = pick(bus.req, last_p0);
          grant_nxt = 5'b00001 << sel_nxt;
          cnt_nxt   = '0;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        out_nxt = mux5(sel_p0, bus.in0, bus.in1, bus.in2, bus.in3, bus.in4);
        vld_nxt = 1'b1;
        cnt_nxt = cnt_p0 + CNT_W'(1);
        // done and abandon take precedence, so timeout only flags a genuinely forced release
        if (bus.done || !bus.req[sel_p0] || (cnt_p0 == CNT_W'(MAX_HOLD - 1))) begin
          to_nxt    = !bus.done && bus.req[sel_p0];
          grant_nxt = '0;
          last_nxt  = sel_p0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: control state; stage p1: registered owner word one cycle behind sel
  always_ff @(posedge clock) begin
    if (reset) begin
      state_p0 <= IDLE;
      last_p0  <= 3'd4;
      sel_p0   <= '0;
      grant_p0 <= '0;
      cnt_p0   <= '0;
      to_p0    <= 1'b0;
      out_p1   <= '0;
      vld_p1   <= 1'b0;
    end else begin
      state_p0 <= state_nxt;
      last_p0  <= last_nxt;
      sel_p0   <= sel_nxt;
      grant_p0 <= grant_nxt;
      cnt_p0   <= cnt_nxt;
      to_p0    <= to_nxt;
      out_p1   <= out_nxt;
      vld_p1   <= vld_nxt;
    end
  end

  assign bus.grant     = grant_p0;
  assign bus.sel       = sel_p0;
  assign bus.out       = out_p1;
  assign bus.out_valid = vld_p1;
  assign bus.timeout   = to_p0;
endmodule

// File: doc/q31_fiveway_arbiter.md
Name: q31_fiveway_arbiter

Overview:
- Round-robin arbiter that shares one five-input Q31 selector path among five requesters.
- Each requester issues a request and receives a one-hot grant; the block drives the 3-bit select and registers the selected Q31 word.
- The grant is held until the owner signals done, drops its request, or a hold timeout expires.
- Sits in the pre-processor between the requesting sub-blocks and the shared downstream Q31 consumer.

Parameters:
- MAX_HOLD, 64, max cycles one grant may be held before forced release (legal range 2..255).
- CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  5  request lines; bit i belongs to requester i.
- done  input  1  current owner finished; sampled only in BUSY.
- in0..in4  input  32 each  Q31 data from requesters 0..4.
- grant  output  5  one-hot grant; all zero when idle.
- sel  output  3  select code of the current owner (0..4).
- out  output  32  registered Q31 word of the current owner.
- out_valid  output  1  high while out carries the granted requester's data.
- timeout  output  1  one-cycle pulse on forced release.

Behaviour:
Reset (synchronous, active-high):
- grant=0, sel=0, out=0, out_valid=0, timeout=0.
- State=IDLE, hold count=0, last winner=4, so requester 0 has first priority.
- Reset asserted mid-grant aborts the grant at the next edge; nothing else is carried over.

State IDLE:
- If req is nonzero, select the winner by scanning indices last+1, last+2, ... modulo 5. The first set bit wins.
- On that edge: grant=onehot(winner), sel=winner, hold count=0, state=BUSY.
- out and out_valid update one cycle later, because out is registered from sel.
- If req=0, remain in IDLE with grant=0. sel keeps its last value; out_valid=0.

State BUSY:
- Every cycle: out <= in[sel] and out_valid <= 1, so out tracks the owner's input with 1-cycle latency.
- Hold count increments by 1 per BUSY cycle.

Release conditions (evaluated in BUSY, priority order):
- (a) done=1.
- (b) req[sel]=0, meaning the owner abandoned the request.
- (c) hold count reached MAX_HOLD-1. This sets timeout=1 for exactly one cycle.

On release:
- grant=0, last winner=sel, state=IDLE.
- out_valid=0 on the following cycle. out holds its last value.

Timing and edge cases:
- Re-arbitration always takes one IDLE cycle, so back-to-back grants are separated by exactly one cycle with grant=0. This is the minimum gap.
- Only the owner's request matters in BUSY; new requests from others are ignored until the next IDLE.
- done asserted while IDLE is ignored.
- done and the timeout condition in the same cycle: a normal release with timeout=0.
- A single persistent requester is re-granted after each one-cycle gap. Round-robin never starves it, because it is the only candidate.
- sel never takes values 5..7. grant is always one-hot or zero.
- Arithmetic is pass-through only; Q31 values are not modified, saturated or sign-altered.

Test Plan:
- Reset then idle: hold reset 2 cycles, req=0 → grant=0, sel=0, out=0, out_valid=0, timeout=0. No change over 10 cycles.
- Single grant: req=5'b00100, in2=32'h4000_0000 → next edge grant=5'b00100, sel=2. One cycle later out=32'h4000_0000, out_valid=1. Pulse done → grant=0 next edge.
- Round-robin fairness: req=5'b11111 held constant, done pulsed each grant → grant order 0,1,2,3,4,0, with a one-cycle zero-grant gap between each.
- Abandon: grant to requester 3, then drop req[3] while req[1]=1 → grant=0 next edge, then grant=5'b00010 on the following edge, timeout never asserted.
- Timeout: MAX_HOLD=4, req[0] held, done=0 → grant held 4 cycles, timeout=1 for one cycle with grant=0. With req[0] still high, re-grant to 0 one cycle later.
- Reset mid-grant: grant to requester 4, out_valid=1, assert reset → next edge all outputs at reset values. After release, req=5'b10001 → requester 0 wins first.
